// File: rtl/predecode_queue.sv
// Instruction buffer between fetch and decode: accepts up to FETCH_WIDTH words per
// cycle, predecodes each lane on entry and issues one predecoded entry per cycle.
module predecode_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload while valid && !ready, and ready never looks at valid.
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FETCH_WIDTH-1:0]   in_mask,
  input  logic [31:0]              in_pc,
  input  logic [32*FETCH_WIDTH-1:0] in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_imm,
  output logic [4:0]               out_waddr,
  output logic [4:0]               out_raddr1,
  output logic [4:0]               out_raddr2,
  output logic                     out_wren,
  output logic                     out_rden1,
  output logic                     out_rden2,
  output logic [10:0]              out_class,
  output logic                     out_nop,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wren;
    logic        rden1;
    logic        rden2;
    logic [10:0] cls;
    logic        nop;
    logic        illegal;
  } entry_t;

  function automatic entry_t predecode(input logic [31:0] pc, input logic [31:0] instr);
    entry_t      e;
    logic [10:0] c;
    logic [2:0]  f3;
    logic        bad;
    e  = '0;
    c  = '0;
    f3 = instr[14:12];
    case (instr[6:0])
      7'h37:   c[0]  = 1'b1;
      7'h17:   c[1]  = 1'b1;
      7'h6f:   c[2]  = 1'b1;
      7'h67:   c[3]  = 1'b1;
      7'h63:   c[4]  = 1'b1;
      7'h03:   c[5]  = 1'b1;
      7'h23:   c[6]  = 1'b1;
      7'h13:   c[7]  = 1'b1;
      7'h33:   c[8]  = 1'b1;
      7'h0f:   c[9]  = 1'b1;
      7'h73:   c[10] = 1'b1;
      default: c     = '0;
    endcase
    bad = (instr[1:0] != 2'b11) || (c == '0) ||
          (c[4] && (f3 == 3'd2 || f3 == 3'd3)) ||
          (c[5] && (f3 == 3'd3 || f3 >= 3'd6)) ||
          (c[6] && f3 > 3'd2) ||
          (c[10] && f3 == 3'd4);
    e.pc     = pc;
    e.instr  = instr;
    e.waddr  = instr[11:7];
    e.raddr1 = instr[19:15];
    e.raddr2 = instr[24:20];
    e.nop    = (instr == 32'h0000_0013);
    e.illegal = bad;
    if (!bad) begin
      e.cls = c;
      if (c[0] || c[1])              e.imm = {instr[31:12], 12'b0};
      else if (c[2])                 e.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      else if (c[3] || c[5] || c[7]) e.imm = {{20{instr[31]}}, instr[31:20]};
      else if (c[4])                 e.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      else if (c[6])                 e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      else if (c[10])                e.imm = {27'b0, instr[19:15]};
      else                           e.imm = '0;
      e.wren  = (instr[11:7] != 5'd0) &&
                (c[0] || c[1] || c[2] || c[3] || c[5] || c[7] || c[8] || (c[10] && f3 != 3'd0));
      e.rden1 = c[3] || c[4] || c[5] || c[6] || c[7] || c[8] ||
                (c[10] && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3));
      e.rden2 = c[4] || c[6] || c[8];
    end
    return e;
  endfunction

  entry_t          mem [DEPTH];
  entry_t          lane_entry [FETCH_WIDTH];
  logic [AW-1:0]   lane_idx [FETCH_WIDTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   push_cnt;
  logic            push;
  logic            pop;
  entry_t          head;

  assign count     = wr_ptr - rd_ptr;
  assign in_ready  = count <= PW'(DEPTH - FETCH_WIDTH);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_entry[i] = predecode(in_pc + 32'(4 * i), in_instr[32*i +: 32]);
      lane_idx[i]   = wr_ptr[AW-1:0] + AW'(i);
      if (in_mask[i]) push_cnt = push_cnt + PW'(1);
    end
  end

  // Flush rewinds the pointers only; stale entries are unreachable until overwritten.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + push_cnt;
        for (int i = 0; i < FETCH_WIDTH; i++)
          if (in_mask[i]) mem[lane_idx[i]] <= lane_entry[i];
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_imm     = head.imm;
  assign out_waddr   = head.waddr;
  assign out_raddr1  = head.raddr1;
  assign out_raddr2  = head.raddr2;
  assign out_wren    = head.wren;
  assign out_rden1   = head.rden1;
  assign out_rden2   = head.rden2;
  assign out_class   = head.cls;
  assign out_nop     = head.nop;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_predecode_queue.sv
// Directed bench for predecode_queue: handshake, fill/drain ordering, wrap, flush,
// predecode of representative encodings and asynchronous reset.
module tb_predecode_queue;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mask;
  logic [31:0] in_pc;
  logic [63:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic [4:0]  out_waddr;
  logic [4:0]  out_raddr1;
  logic [4:0]  out_raddr2;
  logic        out_wren;
  logic        out_rden1;
  logic        out_rden2;
  logic [10:0] out_class;
  logic        out_nop;
  logic        out_illegal;
  logic [3:0]  count;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] BEQ  = 32'hFE20_8EE3;
  localparam logic [31:0] CSRR = 32'h3000_22F3;
  localparam logic [31:0] LUI  = 32'h1234_52B7;
  localparam logic [31:0] SW   = 32'h0020_A423;
  localparam logic [31:0] LD   = 32'h0000_B083;

  predecode_queue #(.DEPTH(8), .FETCH_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_imm(out_imm),
    .out_waddr(out_waddr), .out_raddr1(out_raddr1), .out_raddr2(out_raddr2),
    .out_wren(out_wren), .out_rden1(out_rden1), .out_rden2(out_rden2),
    .out_class(out_class), .out_nop(out_nop), .out_illegal(out_illegal),
    .count(count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] mask, input logic acc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = {i1, i0};
    in_mask  = mask;
    chk("in_ready", 32'(in_ready), 32'(acc));
    if (acc) begin
      if (mask[0]) exp_q.push_back(pc);
      if (mask[1]) exp_q.push_back(pc + 32'd4);
    end
    tick();
    in_valid = 1'b0;
    in_mask  = 2'b00;
  endtask

  task automatic pop_chk();
    chk("pop_valid", 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) chk("exp_q_empty", 32'd1, 32'd0);
    else chk("drain_pc", out_pc, exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = '0;
    in_pc = '0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // reset state and pop on empty
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_class", 32'(out_class), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);

    // two-lane push: addi then beq
    push(32'h100, ADDI, BEQ, 2'b11, 1'b1);
    chk("addi_count", 32'(count), 32'd2);
    chk("addi_class", 32'(out_class), 32'h080);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_waddr", 32'(out_waddr), 32'd1);
    chk("addi_wren", 32'(out_wren), 32'd1);
    chk("addi_rden1", 32'(out_rden1), 32'd1);
    chk("addi_rden2", 32'(out_rden2), 32'd0);
    chk("addi_instr", out_instr, ADDI);
    pop_chk();
    chk("beq_class", 32'(out_class), 32'h010);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_rden1", 32'(out_rden1), 32'd1);
    chk("beq_rden2", 32'(out_rden2), 32'd1);
    chk("beq_wren", 32'(out_wren), 32'd0);
    chk("beq_raddr1", 32'(out_raddr1), 32'd1);
    chk("beq_raddr2", 32'(out_raddr2), 32'd2);
    pop_chk();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // fill to full with no consumer, then reject a further group
    for (int k = 0; k < 4; k++) begin
      push(32'h200 + 32'(8 * k), NOP, NOP, 2'b11, 1'b1);
      chk("fill_count", 32'(count), 32'(2 * (k + 1)));
    end
    chk("full_valid", 32'(out_valid), 32'd1);
    push(32'h280, ADDI, ADDI, 2'b11, 1'b0);
    chk("full_hold", 32'(count), 32'd8);
    for (int k = 0; k < 8; k++) pop_chk();
    chk("fill_drain_count", 32'(count), 32'd0);

    // single lane, then push 2 + pop 1 at count 3, then wrap across index 7
    push(32'h300, NOP, ADDI, 2'b01, 1'b1);
    chk("mask1_count", 32'(count), 32'd1);
    push(32'h310, NOP, NOP, 2'b11, 1'b1);
    chk("c3_count", 32'(count), 32'd3);
    in_valid = 1'b1; in_pc = 32'h320; in_instr = {NOP, NOP}; in_mask = 2'b11;
    out_ready = 1'b1;
    chk("sim_head_pc", out_pc, exp_q.pop_front());
    exp_q.push_back(32'h320);
    exp_q.push_back(32'h324);
    tick();
    in_valid = 1'b0; in_mask = 2'b00; out_ready = 1'b0;
    chk("sim_count", 32'(count), 32'd4);
    push(32'h330, NOP, NOP, 2'b11, 1'b1);
    push(32'h338, NOP, NOP, 2'b11, 1'b1);
    chk("wrap_count", 32'(count), 32'd8);
    for (int k = 0; k < 8; k++) pop_chk();

    // flush at count 5 with a simultaneous push
    push(32'h400, NOP, NOP, 2'b11, 1'b1);
    push(32'h408, NOP, NOP, 2'b11, 1'b1);
    push(32'h410, NOP, NOP, 2'b01, 1'b1);
    chk("preflush_count", 32'(count), 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h480; in_instr = {NOP, NOP}; in_mask = 2'b11;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_mask = 2'b00;
    exp_q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    push(32'h500, ADDI, NOP, 2'b01, 1'b1);
    chk("postflush_count", 32'(count), 32'd1);
    pop_chk();

    // illegal and special encodings
    push(32'h600, 32'h0000_00F0, NOP, 2'b11, 1'b1);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_class", 32'(out_class), 32'd0);
    chk("ill_imm", out_imm, 32'd0);
    pop_chk();
    chk("nop_flag", 32'(out_nop), 32'd1);
    chk("nop_wren", 32'(out_wren), 32'd0);
    chk("nop_class", 32'(out_class), 32'h080);
    pop_chk();
    push(32'h700, CSRR, LUI, 2'b11, 1'b1);
    chk("csr_class", 32'(out_class), 32'h400);
    chk("csr_wren", 32'(out_wren), 32'd1);
    chk("csr_rden1", 32'(out_rden1), 32'd1);
    chk("csr_waddr", 32'(out_waddr), 32'd5);
    chk("csr_imm", out_imm, 32'd0);
    pop_chk();
    chk("lui_class", 32'(out_class), 32'h001);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_rden1", 32'(out_rden1), 32'd0);
    chk("lui_pc", out_pc, 32'h704);
    pop_chk();
    push(32'h800, SW, LD, 2'b11, 1'b1);
    chk("sw_class", 32'(out_class), 32'h040);
    chk("sw_imm", out_imm, 32'd8);
    chk("sw_en", {29'd0, out_wren, out_rden1, out_rden2}, 32'b011);
    pop_chk();
    chk("ld3_illegal", 32'(out_illegal), 32'd1);
    chk("ld3_class", 32'(out_class), 32'd0);
    chk("ld3_wren", 32'(out_wren), 32'd0);
    pop_chk();

    // asynchronous reset in the middle of a burst
    push(32'h900, ADDI, BEQ, 2'b11, 1'b1);
    push(32'h908, ADDI, BEQ, 2'b11, 1'b1);
    chk("burst_count", 32'(count), 32'd4);
    #3 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_imm", out_imm, 32'd0);
    #1 reset = 1'b0;
    exp_q.delete();
    tick();
    chk("post_arst_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
